// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - request encodings and controller state type for the data cache
package dcache_pkg;

  // Request opcodes on rw_flag; any other value is treated as no request
  localparam logic [2:0] DC_NOP   = 3'd0;
  localparam logic [2:0] DC_READ  = 3'd1;
  localparam logic [2:0] DC_WRITE = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_REFILL,
    ST_WRITE,
    ST_RESP
  } dc_state_t;

endpackage

// File: rtl/dcache_array.sv
// rtl/dcache_array.sv - valid/tag/data storage for a direct-mapped cache
module dcache_array #(
  parameter int INDEX_BITS = 6,
  parameter int LINE_WORDS = 4,
  parameter int TAG_BITS   = 22
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [INDEX_BITS-1:0]         line_index,
  input  logic [$clog2(LINE_WORDS)-1:0] rd_offset,
  output logic                          rd_valid,
  output logic [TAG_BITS-1:0]           rd_tag,
  output logic [31:0]                   rd_word,
  input  logic                          wr_en,
  input  logic [$clog2(LINE_WORDS)-1:0] wr_offset,
  input  logic [31:0]                   wr_data,
  input  logic [3:0]                    wr_mask,
  input  logic                          set_en,
  input  logic                          clr_en,
  input  logic [TAG_BITS-1:0]           set_tag
);

  localparam int OFF_BITS = $clog2(LINE_WORDS);
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int WORDS    = LINES * LINE_WORDS;

  logic [LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [31:0]         data_q [WORDS];

  logic [INDEX_BITS+OFF_BITS-1:0] rd_addr;
  logic [INDEX_BITS+OFF_BITS-1:0] wr_addr;

  // Combinational lookup of the addressed line and word
  always_comb begin
    rd_addr  = {line_index, rd_offset};
    wr_addr  = {line_index, wr_offset};
    rd_valid = valid_q[line_index];
    rd_tag   = tag_q[line_index];
    rd_word  = data_q[rd_addr];
  end

  // Valid bits: cleared wholesale on reset, set when a refill completes, dropped when one starts
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (set_en) begin
      valid_q[line_index] <= 1'b1;
    end else if (clr_en) begin
      valid_q[line_index] <= 1'b0;
    end
  end

  // Tag written together with the valid bit at the end of a refill
  always_ff @(posedge clk) begin
    if (set_en) begin
      tag_q[line_index] <= set_tag;
    end
  end

  // Byte-masked word write, shared by refill beats and store merges
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_mask[b]) begin
          data_q[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dcache.sv
// rtl/dcache.sv - direct-mapped write-through data cache with multi-beat line refill
module dcache
  import dcache_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  rw_flag,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic [3:0]  write_mask,
  output logic [31:0] read_data,
  output logic        busy,
  output logic        done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int OFF_BITS = $clog2(LINE_WORDS);
  localparam int TAG_BITS = 30 - OFF_BITS - INDEX_BITS;
  localparam logic [OFF_BITS-1:0] LAST_BEAT = OFF_BITS'(LINE_WORDS - 1);

  dc_state_t state_q, state_d;

  // Latched request; only the word address is kept since accesses are whole words
  logic [29:0]         req_word_q;
  logic [31:0]         req_wdata_q;
  logic [3:0]          req_wmask_q;
  logic                req_write_q;
  logic [OFF_BITS-1:0] beat_q;
  logic [31:0]         resp_q;

  logic [OFF_BITS-1:0]   req_offset;
  logic [INDEX_BITS-1:0] req_index;
  logic [TAG_BITS-1:0]   req_tag;
  logic                  accept;
  logic                  hit;
  logic                  unused_addr_bits;

  logic                  arr_valid;
  logic [TAG_BITS-1:0]   arr_tag;
  logic [31:0]           arr_word;
  logic                  arr_wr_en;
  logic [OFF_BITS-1:0]   arr_wr_offset;
  logic [31:0]           arr_wr_data;
  logic [3:0]            arr_wr_mask;
  logic                  arr_set;
  logic                  arr_clr;

  // Address split and hit detection against the latched request
  always_comb begin
    req_offset       = req_word_q[OFF_BITS-1:0];
    req_index        = req_word_q[OFF_BITS +: INDEX_BITS];
    req_tag          = req_word_q[29 -: TAG_BITS];
    accept           = (state_q == ST_IDLE) && ((rw_flag == DC_READ) || (rw_flag == DC_WRITE));
    hit              = arr_valid && (arr_tag == req_tag);
    unused_addr_bits = ^addr[1:0];
  end

  dcache_array #(
    .INDEX_BITS (INDEX_BITS),
    .LINE_WORDS (LINE_WORDS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .line_index (req_index),
    .rd_offset  (req_offset),
    .rd_valid   (arr_valid),
    .rd_tag     (arr_tag),
    .rd_word    (arr_word),
    .wr_en      (arr_wr_en),
    .wr_offset  (arr_wr_offset),
    .wr_data    (arr_wr_data),
    .wr_mask    (arr_wr_mask),
    .set_en     (arr_set),
    .clr_en     (arr_clr),
    .set_tag    (req_tag)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request latch, loaded only when a new request is taken in IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      req_word_q  <= '0;
      req_wdata_q <= '0;
      req_wmask_q <= '0;
      req_write_q <= 1'b0;
    end else if (accept) begin
      req_word_q  <= addr[31:2];
      req_wdata_q <= write_data;
      req_wmask_q <= write_mask;
      req_write_q <= (rw_flag == DC_WRITE);
    end
  end

  // Beat counter and response word: hit data in LOOKUP, or the requested beat during refill
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q <= '0;
      resp_q <= '0;
    end else begin
      if (accept) begin
        resp_q <= '0;
      end
      if (state_q == ST_LOOKUP) begin
        beat_q <= '0;
        if (hit && !req_write_q) begin
          resp_q <= arr_word;
        end
      end
      if ((state_q == ST_REFILL) && mem_ack) begin
        beat_q <= beat_q + OFF_BITS'(1);
        if (beat_q == req_offset) begin
          resp_q <= mem_rdata;
        end
      end
    end
  end

  // Next-state, memory-port and array-control decode
  always_comb begin
    state_d       = state_q;
    busy          = (state_q != ST_IDLE);
    done          = 1'b0;
    read_data     = '0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_wmask     = '0;
    arr_wr_en     = 1'b0;
    arr_wr_offset = req_offset;
    arr_wr_data   = req_wdata_q;
    arr_wr_mask   = req_wmask_q;
    arr_set       = 1'b0;
    arr_clr       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (!req_write_q) begin
          if (hit) begin
            state_d = ST_RESP;
          end else begin
            // Line is invalidated up front so an abandoned refill never leaves it half-valid
            arr_clr = 1'b1;
            state_d = ST_REFILL;
          end
        end else if (req_wmask_q != 4'b0000) begin
          arr_wr_en = hit;
          state_d   = ST_WRITE;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {req_word_q[29:OFF_BITS], beat_q, 2'b00};
        if (mem_ack) begin
          arr_wr_en     = 1'b1;
          arr_wr_offset = beat_q;
          arr_wr_data   = mem_rdata;
          arr_wr_mask   = 4'hF;
          if (beat_q == LAST_BEAT) begin
            arr_set = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {req_word_q, 2'b00};
        mem_wdata = req_wdata_q;
        mem_wmask = req_wmask_q;
        if (mem_ack) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        done      = 1'b1;
        read_data = resp_q;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
